// File: rtl/control_unit.sv
// Instruction sequencer for the 8-bit CPU: fetches opcode/operand pairs, gathers
// X-mode data bytes, pulses Exec for the ALU, and handles STORE, JUMP and HALT itself.
//
// state   | meaning
// FETCH   | read opcode byte at pc
// DECODE  | latch IR, read operand byte at pc+1
// OPERAND | latch IBR, branch on instruction class
// MEMRD   | read data byte at IBR (X-mode ALU op)
// MEMCAP  | latch MBR
// EXEC    | one-cycle ALU commit pulse
// STORE   | write AR to IBR
// HALT    | idle until reset
module control_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] AR,
  input  logic [3:0]       Flags,
  output logic [WIDTH-1:0] IR,
  output logic [WIDTH-1:0] IBR,
  output logic [WIDTH-1:0] MBR,
  output logic             Exec,
  output logic [WIDTH-1:0] pc,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_OPERAND, S_MEMRD, S_MEMCAP, S_EXEC, S_STORE, S_HALT
  } state_t;

  state_t state, state_nxt;

  logic [1:0]       ir_class;
  logic             ir_xmode;
  logic             jump_take;
  logic [WIDTH-1:0] pc_inc;

  assign ir_class  = IR[7:6];
  assign ir_xmode  = IR[5];
  assign pc_inc    = pc + WIDTH'(1);
  assign mem_wdata = AR;

  always_comb begin
    jump_take = 1'b0;
    case (IR[2:0])
      3'b000:  jump_take = 1'b1;
      3'b001:  jump_take = Flags[2];
      3'b010:  jump_take = Flags[0];
      3'b011:  jump_take = Flags[3];
      3'b100:  jump_take = Flags[1];
      default: jump_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) state <= S_FETCH;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = S_OPERAND;
      S_OPERAND: begin
        case (ir_class)
          2'b11:   state_nxt = S_HALT;
          2'b10:   state_nxt = S_FETCH;
          2'b01:   state_nxt = S_STORE;
          default: state_nxt = ir_xmode ? S_MEMRD : S_EXEC;
        endcase
      end
      S_MEMRD:   state_nxt = S_MEMCAP;
      S_MEMCAP:  state_nxt = S_EXEC;
      S_EXEC:    state_nxt = S_FETCH;
      S_STORE:   state_nxt = S_FETCH;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_FETCH;
    endcase
  end

  // Datapath registers; reset wins so a pending MBR capture is dropped.
  always_ff @(posedge clk) begin
    if (arst) begin
      pc  <= '0;
      IR  <= '0;
      IBR <= '0;
      MBR <= '0;
    end else begin
      case (state)
        S_DECODE: begin
          IR <= mem_rdata;
          pc <= pc_inc;
        end
        S_OPERAND: begin
          IBR <= mem_rdata;
          if (ir_class == 2'b10)      pc <= jump_take ? mem_rdata : pc_inc;
          else if (ir_class != 2'b11) pc <= pc_inc;
        end
        S_MEMCAP: MBR <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_addr = pc;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    Exec     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH:  mem_rd = 1'b1;
      S_DECODE: begin
        mem_addr = pc_inc;
        mem_rd   = 1'b1;
      end
      S_MEMRD: begin
        mem_addr = IBR;
        mem_rd   = 1'b1;
      end
      S_STORE: begin
        mem_addr = IBR;
        mem_wr   = 1'b1;
      end
      S_EXEC:  Exec   = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: directed programs push expected bus events,
// a negedge monitor pops and compares each event the sequencer presents.
module tb_control_unit;

  logic       clk;
  logic       arst;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] AR;
  logic [3:0] Flags;
  logic [7:0] IR;
  logic [7:0] IBR;
  logic [7:0] MBR;
  logic       Exec;
  logic [7:0] pc;
  logic       halted;

  control_unit #(.WIDTH(8)) dut (
    .clk(clk), .arst(arst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .AR(AR), .Flags(Flags),
    .IR(IR), .IBR(IBR), .MBR(MBR), .Exec(Exec), .pc(pc), .halted(halted)
  );

  localparam logic [7:0] K_RD = 8'd1, K_WR = 8'd2, K_EX = 8'd3, K_HT = 8'd4, K_RS = 8'd5;

  logic [7:0]  mem [256];
  logic [55:0] exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic        prev_halted = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous read memory; writes are observed by the monitor only.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk) begin
    if (arst) cyc <= 1;
    else      cyc <= cyc + 1;
  end

  function automatic string kname(input logic [7:0] k);
    case (k)
      K_RD:    return "read";
      K_WR:    return "write";
      K_EX:    return "exec";
      K_HT:    return "halt";
      K_RS:    return "reset_state";
      default: return "event";
    endcase
  endfunction

  task automatic check_ev(input logic [55:0] got);
    logic [55:0] want;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s cyc=%0d got=%h required=none", kname(got[55:48]), cyc, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        n_err++;
        $display("FAIL %s cyc=%0d got=%h required=%h", kname(want[55:48]), cyc, got, want);
      end
    end
  endtask

  always @(negedge clk) begin
    prev_halted <= halted;
    if (!arst) begin
      n_vec++;
      if ((mem_rd && mem_wr) || (Exec && (mem_rd || mem_wr))) begin
        n_err++;
        $display("FAIL strobe_overlap cyc=%0d got rd=%b wr=%b exec=%b required=exclusive",
                 cyc, mem_rd, mem_wr, Exec);
      end
      if (cyc == 1)
        check_ev({K_RS, 8'd1, pc, IR, IBR, MBR, {4'b0, mem_rd, mem_wr, Exec, halted}});
      if (mem_rd) check_ev({K_RD, 8'(cyc), mem_addr, pc, 24'h0});
      if (mem_wr) check_ev({K_WR, 8'(cyc), mem_addr, mem_wdata, {7'b0, Exec}, 16'h0});
      if (Exec)   check_ev({K_EX, 8'(cyc), IR, IBR, MBR, 16'h0});
      if (halted && !prev_halted)
        check_ev({K_HT, 8'(cyc), pc, {7'b0, mem_rd | mem_wr | Exec}, 24'h0});
    end
  end

  task automatic exp_rd(input int c, input logic [7:0] a, input logic [7:0] p);
    exp_q.push_back({K_RD, 8'(c), a, p, 24'h0});
  endtask
  task automatic exp_wr(input int c, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back({K_WR, 8'(c), a, d, 8'h00, 16'h0});
  endtask
  task automatic exp_ex(input int c, input logic [7:0] ir, input logic [7:0] ibr,
                        input logic [7:0] mbr);
    exp_q.push_back({K_EX, 8'(c), ir, ibr, mbr, 16'h0});
  endtask
  task automatic exp_ht(input int c, input logic [7:0] p);
    exp_q.push_back({K_HT, 8'(c), p, 8'h00, 24'h0});
  endtask
  task automatic exp_rst();
    exp_q.push_back({K_RS, 8'd1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08});
  endtask

  task automatic flush_check();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover_events got=%0d required=0 next=%h", exp_q.size(), exp_q[0]);
      exp_q.delete();
    end
  endtask

  // Leaves the bench at cycle 1 (FETCH) with a cleared memory.
  task automatic begin_test();
    arst = 1'b1;
    flush_check();
    @(posedge clk);
    #1;
    arst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    exp_rst();
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] j_op [8];
  logic [3:0] j_fl [8];
  bit         j_tk [8];

  initial begin
    arst  = 1'b1;
    AR    = 8'h00;
    Flags = 4'h0;
    j_op[0] = 8'h81; j_fl[0] = 4'b0100; j_tk[0] = 1'b1;
    j_op[1] = 8'h81; j_fl[1] = 4'b0000; j_tk[1] = 1'b0;
    j_op[2] = 8'h82; j_fl[2] = 4'b0001; j_tk[2] = 1'b1;
    j_op[3] = 8'h83; j_fl[3] = 4'b1000; j_tk[3] = 1'b1;
    j_op[4] = 8'h84; j_fl[4] = 4'b0010; j_tk[4] = 1'b1;
    j_op[5] = 8'h84; j_fl[5] = 4'b1101; j_tk[5] = 1'b0;
    j_op[6] = 8'h85; j_fl[6] = 4'b1111; j_tk[6] = 1'b0;
    j_op[7] = 8'h80; j_fl[7] = 4'b0000; j_tk[7] = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ALU immediate
    begin_test();
    mem[0] = 8'h00; mem[1] = 8'h05;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_ex(4, 8'h00, 8'h05, 8'h00);
    exp_rd(5, 8'h02, 8'h02); exp_rd(6, 8'h03, 8'h02);
    run(6);

    // ALU X-mode
    begin_test();
    mem[0] = 8'h20; mem[1] = 8'h80; mem[8'h80] = 8'h3C;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_rd(4, 8'h80, 8'h02);
    exp_ex(6, 8'h20, 8'h80, 8'h3C);
    exp_rd(7, 8'h02, 8'h02);
    run(7);

    // STORE
    AR = 8'hA5;
    begin_test();
    mem[0] = 8'h40; mem[1] = 8'h90;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_wr(4, 8'h90, 8'hA5);
    exp_rd(5, 8'h02, 8'h02);
    run(5);
    AR = 8'h00;

    // Conditional jumps
    for (int t = 0; t < 8; t++) begin
      Flags = j_fl[t];
      begin_test();
      mem[0] = j_op[t]; mem[1] = 8'h10;
      exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
      if (j_tk[t]) begin
        exp_rd(4, 8'h10, 8'h10); exp_rd(5, 8'h11, 8'h10);
      end else begin
        exp_rd(4, 8'h02, 8'h02); exp_rd(5, 8'h03, 8'h02);
      end
      run(5);
    end
    Flags = 4'h0;

    // HALT: no strobes for 20 cycles; next begin_test checks release by reset
    begin_test();
    mem[0] = 8'hC0; mem[1] = 8'h00;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_ht(4, 8'h01);
    run(24);

    // pc wrap: jump to 0xFF, ALU I opcode there takes operand from 0x00
    begin_test();
    mem[0] = 8'h80; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_rd(4, 8'hFF, 8'hFF); exp_rd(5, 8'h00, 8'hFF);
    exp_ex(7, 8'h00, 8'h80, 8'h00);
    exp_rd(8, 8'h01, 8'h01);
    run(8);

    // Reset during MEMCAP: no Exec, MBR stays 0
    begin_test();
    mem[0] = 8'h20; mem[1] = 8'h80; mem[8'h80] = 8'h3C;
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    exp_rd(4, 8'h80, 8'h02);
    run(4);
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    exp_rst();
    exp_rd(1, 8'h00, 8'h00); exp_rd(2, 8'h01, 8'h00);
    run(2);

    arst = 1'b1;
    flush_check();
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
